// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : booth_mul_seq
//  Purpose  : Sequential radix-2 Booth signed multiplier. It borrows an
//             external ripple-carry adder through the add_a/add_b ->
//             add_sum/add_cout port pair, one adder operation per Booth
//             step, and produces a 2*WIDTH signed product with an NZCV
//             flag nibble.
//  Ports    : CLK, RST            clock / synchronous active-high reset
//             start               request, accepted only in IDLE
//             multiplicand        signed M, captured on accepted start
//             multiplier          signed Q, captured on accepted start
//             busy                operation in progress (NEG / ITER)
//             done                one-cycle result-valid pulse
//             product             signed M*Q, held until the next result
//             prod_flags          {N,Z,C,V} of product
//             add_a, add_b        operands driven to the external adder
//             add_sum, add_cout   result returned by the external adder
//  Revision : 1.0  initial release
// ============================================================================
module booth_mul_seq #(
    parameter int WIDTH     = 32,
    parameter int ADDER_LAT = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [3:0]           prod_flags,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);

    localparam int c_IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_WW = (ADDER_LAT > 0) ? $clog2(ADDER_LAT + 1) : 1;

    localparam logic [c_IW-1:0] c_ITER_LAST = c_IW'(WIDTH - 1);
    localparam logic [c_WW-1:0] c_WAIT_LAST = c_WW'(ADDER_LAT);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_NEG  = 2'd1;
    localparam logic [1:0] c_S_ITER = 2'd2;
    localparam logic [1:0] c_S_DONE = 2'd3;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]           state_q,   state_d;
    logic [WIDTH-1:0]     a_q,       a_d;
    logic [WIDTH-1:0]     qr_q,      qr_d;
    logic                 q1_q,      q1_d;
    logic [WIDTH-1:0]     mr_q,      mr_d;
    logic [WIDTH-1:0]     negm_q,    negm_d;
    logic [c_IW-1:0]      iter_q,    iter_d;
    logic [c_WW-1:0]      wait_q,    wait_d;
    logic [WIDTH-1:0]     add_a_q,   add_a_d;
    logic [WIDTH-1:0]     add_b_q,   add_b_d;
    logic                 done_q,    done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [3:0]           flags_q,   flags_d;

    // ------------------------------------------------------------------
    // Booth step decode
    // ------------------------------------------------------------------
    logic                 w_use_adder;
    logic                 w_sub;
    logic                 w_bsign;
    logic                 w_ext_sign;
    logic                 w_shift;
    logic [2*WIDTH-1:0]   w_prod;

    // Pairs 01 and 10 need the adder; 00 and 11 are shift-only.
    assign w_use_adder = qr_q[0] ^ q1_q;
    assign w_sub       = qr_q[0] & ~q1_q;

    // Sign of the true (WIDTH+1)-bit addend. negM is stored modulo 2^WIDTH,
    // so for M = most-negative value the stored pattern looks negative while
    // -M is actually positive; ~Mr[MSB] gives the right sign except for M=0.
    assign w_bsign = w_sub ? ((mr_q == '0) ? 1'b0 : ~mr_q[WIDTH-1])
                           : mr_q[WIDTH-1];

    // Bit WIDTH of the exact sum A + B, used as the bit shifted into A.
    assign w_ext_sign = a_q[WIDTH-1] ^ w_bsign ^ add_cout;

    assign w_prod = {a_q, qr_q};

    // ------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= c_S_IDLE;
            a_q       <= '0;
            qr_q      <= '0;
            q1_q      <= 1'b0;
            mr_q      <= '0;
            negm_q    <= '0;
            iter_q    <= '0;
            wait_q    <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            qr_q      <= qr_d;
            q1_q      <= q1_d;
            mr_q      <= mr_d;
            negm_q    <= negm_d;
            iter_q    <= iter_d;
            wait_q    <= wait_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            done_q    <= done_d;
            product_q <= product_d;
            flags_q   <= flags_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        qr_d    = qr_q;
        q1_d    = q1_q;
        mr_d    = mr_q;
        negm_d  = negm_q;
        iter_d  = iter_q;
        wait_d  = wait_q;
        w_shift = 1'b0;

        case (state_q)
            c_S_IDLE: begin
                if (start) begin
                    state_d = c_S_NEG;
                    a_d     = '0;
                    qr_d    = multiplier;
                    q1_d    = 1'b0;
                    mr_d    = multiplicand;
                    iter_d  = '0;
                    wait_d  = '0;
                end
            end

            c_S_NEG: begin
                // The adder computes ~M + 1 = -M.
                if (wait_q == c_WAIT_LAST) begin
                    negm_d  = add_sum;
                    wait_d  = '0;
                    iter_d  = '0;
                    state_d = c_S_ITER;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            c_S_ITER: begin
                if (w_use_adder) begin
                    if (wait_q == c_WAIT_LAST) begin
                        wait_d  = '0;
                        a_d     = {w_ext_sign, add_sum[WIDTH-1:1]};
                        qr_d    = {add_sum[0], qr_q[WIDTH-1:1]};
                        q1_d    = qr_q[0];
                        w_shift = 1'b1;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end else begin
                    a_d     = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
                    qr_d    = {a_q[0], qr_q[WIDTH-1:1]};
                    q1_d    = qr_q[0];
                    w_shift = 1'b1;
                end

                if (w_shift) begin
                    if (iter_q == c_ITER_LAST) begin
                        state_d = c_S_DONE;
                    end else begin
                        iter_d = iter_q + 1'b1;
                    end
                end
            end

            c_S_DONE: begin
                state_d = c_S_IDLE;
            end

            default: begin
                state_d = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: outputs
    // ------------------------------------------------------------------
    // The adder operands are registered, so they are computed from the
    // upcoming state: they are then valid from the first cycle of each
    // NEG window or adder iteration and stay put for the whole wait.
    always_comb begin
        busy      = (state_q == c_S_NEG) || (state_q == c_S_ITER);
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        done_d    = (state_q == c_S_DONE);
        product_d = product_q;
        flags_d   = flags_q;

        case (state_d)
            c_S_NEG: begin
                add_a_d = ~mr_d;
                add_b_d = {{(WIDTH-1){1'b0}}, 1'b1};
            end
            c_S_ITER: begin
                // Shift-only steps leave the operands untouched.
                if (qr_d[0] ^ q1_d) begin
                    add_a_d = a_d;
                    add_b_d = qr_d[0] ? negm_d : mr_d;
                end
            end
            default: begin
                add_a_d = '0;
                add_b_d = '0;
            end
        endcase

        if (state_q == c_S_DONE) begin
            product_d = w_prod;
            flags_d   = {w_prod[2*WIDTH-1], (w_prod == '0), 2'b00};
        end
    end

    assign done       = done_q;
    assign product    = product_q;
    assign prod_flags = flags_q;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_mul_seq
//  Purpose  : Self-checking bench for booth_mul_seq. Three instances run in
//             lockstep with adder latencies 0, 1 and 3, each paired with its
//             own adder model. Products, flags, latency, busy length, done
//             pulse count and operand stability are checked against values
//             computed from plain signed arithmetic and the Booth pair rule.
//  Revision : 1.0  initial release
// ============================================================================
module tb_booth_mul_seq;

    localparam int c_N = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      mcand;
    logic [31:0]      mplier;

    logic [c_N-1:0]   busy;
    logic [c_N-1:0]   done;
    logic [c_N-1:0]   add_cout;
    logic [63:0]      product [c_N];
    logic [3:0]       flags   [c_N];
    logic [31:0]      add_a   [c_N];
    logic [31:0]      add_b   [c_N];
    logic [31:0]      add_sum [c_N];
    int               minrun  [c_N];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    // ------------------------------------------------------------------
    // DUT instances, adder models and operand-stability monitors
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < c_N; gi++) begin : g_dut
        localparam int c_LAT = (gi == 0) ? 0 : ((gi == 1) ? 1 : 3);

        logic [32:0] w_full;
        assign w_full = {1'b0, add_a[gi]} + {1'b0, add_b[gi]};

        if (c_LAT == 0) begin : g_comb
            assign add_sum[gi]  = w_full[31:0];
            assign add_cout[gi] = w_full[32];
        end else begin : g_pipe
            logic [32:0] pipe [c_LAT];
            always @(posedge clk) begin
                pipe[0] <= w_full;
                for (int k = 1; k < c_LAT; k++) pipe[k] <= pipe[k-1];
            end
            assign add_sum[gi]  = pipe[c_LAT-1][31:0];
            assign add_cout[gi] = pipe[c_LAT-1][32];
        end

        booth_mul_seq #(
            .WIDTH     (32),
            .ADDER_LAT (c_LAT)
        ) u_dut (
            .CLK          (clk),
            .RST          (rst),
            .start        (start),
            .multiplicand (mcand),
            .multiplier   (mplier),
            .busy         (busy[gi]),
            .done         (done[gi]),
            .product      (product[gi]),
            .prod_flags   (flags[gi]),
            .add_a        (add_a[gi]),
            .add_b        (add_b[gi]),
            .add_sum      (add_sum[gi]),
            .add_cout     (add_cout[gi])
        );

        // Shortest run of unchanged {add_a,add_b} seen while busy; every
        // completed run must cover a full adder window of c_LAT+1 cycles.
        logic        in_op = 1'b0;
        int          run   = 0;
        int          mr    = 1000;
        logic [63:0] prev  = '0;
        always @(posedge clk) begin
            if (busy[gi]) begin
                if (!in_op) begin
                    in_op <= 1'b1;
                    run   <= 1;
                    mr    <= 1000;
                    prev  <= {add_a[gi], add_b[gi]};
                end else if ({add_a[gi], add_b[gi]} == prev) begin
                    run <= run + 1;
                end else begin
                    if (run < mr) mr <= run;
                    run  <= 1;
                    prev <= {add_a[gi], add_b[gi]};
                end
            end else begin
                in_op <= 1'b0;
            end
        end
        assign minrun[gi] = mr;
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the start edge to done: one capture cycle, the negation
    // window, then one cycle per shift-only step and a full adder window
    // for every step where the Booth pair {Q[b], Q[b-1]} differs.
    function automatic int expect_cycles(input logic [31:0] q, input int lat);
        int   total;
        logic prev_bit;
        total    = 1 + (lat + 1);
        prev_bit = 1'b0;
        for (int b = 0; b < 32; b++) begin
            total   += (q[b] != prev_bit) ? (lat + 1) : 1;
            prev_bit = q[b];
        end
        return total;
    endfunction

    task automatic check_idle_zero(input string tag);
        for (int i = 0; i < c_N; i++) begin
            check64($sformatf("%s L%0d busy", tag, lat_of(i)),  {63'd0, busy[i]}, 64'd0);
            check64($sformatf("%s L%0d done", tag, lat_of(i)),  {63'd0, done[i]}, 64'd0);
            check64($sformatf("%s L%0d prod", tag, lat_of(i)),  product[i], 64'd0);
            check64($sformatf("%s L%0d flags", tag, lat_of(i)), {60'd0, flags[i]}, 64'd0);
            check64($sformatf("%s L%0d add_a", tag, lat_of(i)), {32'd0, add_a[i]}, 64'd0);
            check64($sformatf("%s L%0d add_b", tag, lat_of(i)), {32'd0, add_b[i]}, 64'd0);
        end
    endtask

    // One multiply on all instances; optionally pulse start again while busy.
    task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                          input int glitch_at, input string tag);
        logic signed [63:0] exp_p;
        logic [3:0]         exp_f;
        int                 exp_lat  [c_N];
        int                 got_lat  [c_N];
        int                 busy_cnt [c_N];
        int                 pulses   [c_N];
        logic [63:0]        got_p    [c_N];
        logic [3:0]         got_f    [c_N];
        int                 c;
        int                 extra;
        bit                 all_done;

        exp_p = $signed({{32{m[31]}}, m}) * $signed({{32{q[31]}}, q});
        exp_f = {exp_p[63], (exp_p == 64'sd0), 2'b00};
        for (int i = 0; i < c_N; i++) begin
            exp_lat[i]  = expect_cycles(q, lat_of(i));
            got_lat[i]  = -1;
            busy_cnt[i] = 0;
            pulses[i]   = 0;
            got_p[i]    = '0;
            got_f[i]    = '0;
        end

        mcand  = m;
        mplier = q;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;

        c     = 0;
        extra = 0;
        while (c < 400 && extra < 3) begin
            all_done = 1'b1;
            for (int i = 0; i < c_N; i++) begin
                if (busy[i]) busy_cnt[i]++;
                if (done[i]) begin
                    pulses[i]++;
                    if (got_lat[i] < 0) begin
                        got_lat[i] = c;
                        got_p[i]   = product[i];
                        got_f[i]   = flags[i];
                    end
                end
                if (got_lat[i] < 0) all_done = 1'b0;
            end
            if (all_done) extra++;
            if (c == glitch_at) begin
                start  = 1'b1;
                mcand  = $urandom;
                mplier = $urandom;
            end else begin
                start = 1'b0;
            end
            tick();
            c++;
        end
        start = 1'b0;

        for (int i = 0; i < c_N; i++) begin
            check64($sformatf("%s L%0d product", tag, lat_of(i)), got_p[i], exp_p);
            check64($sformatf("%s L%0d flags", tag, lat_of(i)), {60'd0, got_f[i]}, {60'd0, exp_f});
            check_int($sformatf("%s L%0d latency", tag, lat_of(i)), got_lat[i], exp_lat[i]);
            check_int($sformatf("%s L%0d busy cycles", tag, lat_of(i)), busy_cnt[i], exp_lat[i] - 1);
            check_int($sformatf("%s L%0d done pulses", tag, lat_of(i)), pulses[i], 1);
            check_int($sformatf("%s L%0d operand hold", tag, lat_of(i)),
                      (minrun[i] >= lat_of(i) + 1) ? lat_of(i) + 1 : minrun[i], lat_of(i) + 1);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed and random sequence
    // ------------------------------------------------------------------
    initial begin
        int dsum;

        rst    = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (3) tick();
        check_idle_zero("reset");
        rst = 1'b0;
        tick();

        run_op(32'd10,        32'd5,         -1, "10*5");
        run_op(32'hFFFF_FFF6, 32'hFFFF_FFFB, -1, "-10*-5");
        run_op(32'hFFFF_FFF6, 32'd5,         -1, "-10*5");
        run_op(32'd0,         32'd1,         -1, "0*1");
        run_op(32'd0,         32'd0,         -1, "0*0");
        run_op(32'h8000_0000, 32'h8000_0000, -1, "min*min");
        run_op(32'h8000_0000, 32'd1,         -1, "min*1");
        run_op(32'd7,         32'hFFFF_FFFF, -1, "7*-1");

        // A second start while busy must not disturb the running product.
        run_op(32'd123456,    32'hFFFF_FCEB, 20, "start-while-busy");

        // Abort mid-iteration: everything clears, no done follows.
        mcand  = 32'h1234_5678;
        mplier = 32'h0F0F_0F0F;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (12) tick();
        rst = 1'b1;
        tick();
        check_idle_zero("abort");
        rst  = 1'b0;
        dsum = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            for (int i = 0; i < c_N; i++) dsum += int'(done[i]);
        end
        check_int("abort no done", dsum, 0);
        run_op(32'hDEAD_BEEF, 32'h0000_1235, -1, "after-abort");

        for (int r = 0; r < 12; r++) begin
            run_op($urandom, $urandom, (r % 4 == 3) ? 15 : -1, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Sequential radix-2 Booth signed multiplier that sits in front of the `rca` adder stage. It both feeds the adder and consumes its output.
- Each iteration drives one adder operation through the shared adder port pair and samples the returned sum and carry.
- Result is a 2*WIDTH signed product with an NZCV flag nibble, matching the `rca` flag format.
- Gives the ALU its MUL operation without a second adder.

Parameters:
- WIDTH, 32, operand width; must equal the `rca` width.
- ADDER_LAT, 1, cycles from add_a/add_b being registered to add_sum/add_cout being valid. 0 means combinational.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- start  in  1  begin a multiply; sampled only in IDLE.
- multiplicand  in  WIDTH  signed M; captured on the accepted start.
- multiplier  in  WIDTH  signed Q; captured on the accepted start.
- busy  out  1  high from the cycle after an accepted start until the last iteration completes.
- done  out  1  one-cycle pulse; product and prod_flags are valid from this cycle on.
- product  out  2*WIDTH  signed M*Q.
- prod_flags  out  4  {N,Z,C,V} of product.
- add_a  out  WIDTH  adder operand a.
- add_b  out  WIDTH  adder operand b.
- add_sum  in  WIDTH  adder result.
- add_cout  in  1  adder carry out.

Behaviour:
- Reset: state IDLE; busy, done, product, prod_flags, add_a, add_b all 0. Reset in any state aborts the operation with no done pulse.
- Registered state:
  - A (WIDTH) accumulator, cleared on start.
  - Qr (WIDTH) loaded with multiplier.
  - q_1 cleared to 0.
  - Mr holds the multiplicand.
  - negM holds the negated multiplicand.
  - iter counter, 0..WIDTH-1.
  - wait counter, 0..ADDER_LAT.
- FSM states: IDLE, NEG, ITER, DONE.
- IDLE:
  - start=1 captures the operands and moves to NEG.
  - start is ignored in every other state.
- NEG:
  - Drive add_a=~Mr, add_b=1.
  - After ADDER_LAT wait cycles, latch negM=add_sum and go to ITER with iter=0.
  - Total NEG time is ADDER_LAT+1 cycles.
- ITER, pair = {Qr[0], q_1}:
  - 00 or 11: no adder use. Arithmetic-shift {A,Qr,q_1} right by 1 with A's sign, taking 1 cycle.
  - 01: add_a=A, add_b=Mr, and bsign=Mr[31].
  - 10: add_a=A, add_b=negM, and bsign = (Mr==0) ? 0 : ~Mr[WIDTH-1]. This gives the correct sign for Mr = minimum negative value.
  - For 01 and 10, hold operands stable for ADDER_LAT cycles. In the following cycle, shift {add_sum, Qr, q_1} right by 1, shifting in A[WIDTH-1] ^ bsign ^ add_cout (the true 33-bit sign). Total time is ADDER_LAT+1 cycles.
  - After the shift: if iter==WIDTH-1, go to DONE; otherwise iter++.
- DONE (1 cycle):
  - done=1, busy=0.
  - product={A,Qr}; prod_flags: N=product[MSB], Z=(product==0), C=0, V=0.
  - Then go to IDLE.
- product and prod_flags hold their value until the next DONE.
- add_a/add_b are 0 in IDLE and DONE. They hold their last value during shift-only iterations.
- Latency, measured from the edge that samples start: done rises after 1 + (ADDER_LAT+1) + sum of per-iteration cycles.
- Back-to-back operation: start may be asserted during DONE but is ignored. It is accepted in the IDLE cycle that follows.

Test Plan:
- 10*5, ADDER_LAT=1 -> product=50, prod_flags=4'b0000, one done pulse.
- (-10)*(-5) -> 50, flags 0000. (-10)*5 -> 64'hFFFF_FFFF_FFFF_FFCE, flags 4'b1000.
- 0*1 -> product=0, flags 4'b0100. 0*0 with ADDER_LAT=1 -> busy for 34 cycles, done exactly 35 cycles after the start edge.
- 32'h8000_0000*32'h8000_0000 -> 64'h4000_0000_0000_0000. 32'h8000_0000*1 -> 64'hFFFF_FFFF_8000_0000. 7*(-1) -> done 36 cycles after start, product -7.
- start pulsed while busy -> ignored, original result unchanged. RST asserted mid-ITER -> all outputs 0 next cycle, no done, next start gives a correct result.
- Rerun the first four scenarios with ADDER_LAT=0 and ADDER_LAT=3 -> same products. Check that add_a/add_b are stable throughout every wait window.
